// File: rtl/mem_arbiter_rr_if.sv
// Shared native memory bus seen by the arbiter: per-master request lanes on one side,
// the single memory port on the other, plus grant/error status.
interface mem_arbiter_rr_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [NUM_MASTERS-1:0]            m_valid;
    logic [NUM_MASTERS-1:0]            m_instr;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
    logic [NUM_MASTERS*STRB_WIDTH-1:0] m_wstrb;
    logic [NUM_MASTERS-1:0]            m_ready;

    logic                  mem_valid;
    logic                  mem_instr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [STRB_WIDTH-1:0] mem_wstrb;
    logic                  mem_ready;

    logic [NUM_MASTERS-1:0] grant;
    logic                   timeout_err;

    // Arbiter side
    modport master (
        input  m_valid, m_instr, m_addr, m_wdata, m_wstrb, mem_ready,
        output m_ready, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output grant, timeout_err
    );

    // Environment side (masters + memory)
    modport slave (
        output m_valid, m_instr, m_addr, m_wdata, m_wstrb, mem_ready,
        input  m_ready, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  grant, timeout_err
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// N-master arbiter for the native memory bus: registered grant held for a whole
// transaction, fixed or round-robin priority, optional response timeout.
module mem_arbiter_rr #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RR_ENABLE      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    mem_arbiter_rr_if.master  bus
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W      = $clog2(NUM_MASTERS);
    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                 state, state_nxt;
    logic [NUM_MASTERS-1:0] grant, grant_nxt;
    logic [IDX_W-1:0]       gnt_idx, gnt_idx_nxt;
    logic [IDX_W-1:0]       last, last_nxt;
    logic [CNT_W-1:0]       wait_cnt, wait_cnt_nxt;
    logic                   timeout_err, timeout_err_nxt;

    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic                   tmo_hit;

    // Winner search: fixed starts at 0, round-robin starts just past the last winner
    always_comb begin : pick
        int unsigned start;
        int unsigned cand;
        logic [IDX_W-1:0] cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        start     = 0;
        cand      = 0;
        cand_idx  = '0;
        if (RR_ENABLE != 0) begin
            start = 32'(last) + 32'd1;
            if (start >= NUM_MASTERS) start = 0;
        end
        for (int unsigned off = 0; off < NUM_MASTERS; off++) begin
            cand = start + off;
            if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
            cand_idx = IDX_W'(cand);
            if (!win_found && bus.m_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // The TIMEOUT_CYCLES-th BUSY cycle without mem_ready
    always_comb begin : timeout_detect
        tmo_hit = (TIMEOUT_CYCLES != 0) && (state == BUSY) && (wait_cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            gnt_idx     <= '0;
            last        <= LAST_RST;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            gnt_idx     <= gnt_idx_nxt;
            last        <= last_nxt;
            wait_cnt    <= wait_cnt_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

    always_comb begin : next_state
        state_nxt       = state;
        grant_nxt       = grant;
        gnt_idx_nxt     = gnt_idx;
        last_nxt        = last;
        wait_cnt_nxt    = wait_cnt;
        timeout_err_nxt = timeout_err;
        case (state)
            IDLE: begin
                wait_cnt_nxt = '0;
                if (win_found) begin
                    state_nxt   = BUSY;
                    grant_nxt   = NUM_MASTERS'(1) << win_idx;
                    gnt_idx_nxt = win_idx;
                    last_nxt    = win_idx;
                end
            end
            BUSY: begin
                // mem_ready outranks both abort and timeout
                if (bus.mem_ready || !bus.m_valid[gnt_idx]) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end else if (tmo_hit) begin
                    state_nxt       = IDLE;
                    grant_nxt       = '0;
                    timeout_err_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Grant mux toward memory and ready demux back to the masters
    always_comb begin : route
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        bus.m_ready   = '0;
        if (state == BUSY) begin
            bus.mem_valid = bus.m_valid[gnt_idx] & ~tmo_hit;
            bus.mem_instr = bus.m_instr[gnt_idx];
            bus.m_ready   = grant & {NUM_MASTERS{bus.mem_ready}};
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (gnt_idx == IDX_W'(i)) begin
                    bus.mem_addr  = bus.m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    bus.mem_wdata = bus.m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                    bus.mem_wstrb = bus.m_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
                end
            end
        end
    end

    assign bus.grant       = grant;
    assign bus.timeout_err = timeout_err;

endmodule
